// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, then a sign-fix cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] hi_lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q;
    logic [4:0]       count_q;
    logic             isDiv_q;
    logic             negA_q;
    logic             negRes_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] accHi_q;
    logic [WIDTH-1:0] accLo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] accHi_d;
    logic [WIDTH-1:0] accLo_d;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;

    logic             signedOp;
    logic             negA;
    logic             negB;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    logic [2*WIDTH-1:0] mulProd;
    logic [2*WIDTH-1:0] mulFixed;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    // Operand magnitudes and signs captured at launch; unsigned ops keep raw values.
    always_comb begin
        signedOp = ~op[0];
        negA     = signedOp & operand_a[WIDTH-1];
        negB     = signedOp & operand_b[WIDTH-1];
        magA     = negA ? (~operand_a + 1'b1) : operand_a;
        magB     = negB ? (~operand_b + 1'b1) : operand_b;
    end

    // One iteration. Multiply keeps the multiplier in accLo and shifts the
    // product in from the top; divide shifts dividend bits out of accLo into the
    // remainder and shifts quotient bits back into accLo.
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : '0);
        divShift = {accHi_q, accLo_q[WIDTH-1]};
        divDiff  = divShift[WIDTH-1:0] - mcand_q;
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        if (isDiv_q) begin
            if (divShift >= {1'b0, mcand_q}) begin
                accHi_d = divDiff;
                accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
            end else begin
                accHi_d = divShift[WIDTH-1:0];
                accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            accHi_d = mulSum[WIDTH:1];
            accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
        end
    end

    // With a zero divisor every trial subtract succeeds, so the remainder ends
    // up as the dividend magnitude; re-applying its sign restores operand_a.
    always_comb begin
        mulProd  = {accHi_q, accLo_q};
        mulFixed = negRes_q ? (~mulProd + 1'b1) : mulProd;
        if (isDiv_q) begin
            fixHi = negA_q ? (~accHi_q + 1'b1) : accHi_q;
            if (mcand_q == '0) begin
                fixLo = '1;
            end else begin
                fixLo = negRes_q ? (~accLo_q + 1'b1) : accLo_q;
            end
        end else begin
            fixHi = mulFixed[2*WIDTH-1:WIDTH];
            fixLo = mulFixed[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            isDiv_q  <= 1'b0;
            negA_q   <= 1'b0;
            negRes_q <= 1'b0;
            mcand_q  <= '0;
            accHi_q  <= '0;
            accLo_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A launch wins over a same-cycle MTHI/MTLO, which is dropped.
                    if (start) begin
                        state_q  <= CALC;
                        busy_q   <= 1'b1;
                        count_q  <= '0;
                        isDiv_q  <= op[1];
                        negA_q   <= negA;
                        negRes_q <= negA ^ negB;
                        accHi_q  <= '0;
                        mcand_q  <= op[1] ? magB : magA;
                        accLo_q  <= op[1] ? magA : magB;
                    end else begin
                        if (mthi_en) hi_q <= hi_lo_wdata;
                        if (mtlo_en) lo_q <= hi_lo_wdata;
                    end
                end
                CALC: begin
                    accHi_q <= accHi_d;
                    accLo_q <= accLo_d;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fixHi;
                    lo_q    <= fixLo;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: a cycle-level reference model
// built from plain 64-bit arithmetic, checked every cycle, plus directed literals.
module tb_mips_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        mthi_en;
   logic        mtlo_en;
   logic [31:0] hi_lo_wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int testCount = 0;
   int failCount = 0;

   // reference model state
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;
   logic        mDone = 1'b0;
   int          mCnt = 0;
   logic [31:0] pHi;
   logic [31:0] pLo;
   logic        modelValid = 1'b0;

   mips_muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op(op),
      .operand_a(operand_a),
      .operand_b(operand_b),
      .mthi_en(mthi_en),
      .mtlo_en(mtlo_en),
      .hi_lo_wdata(hi_lo_wdata),
      .busy(busy),
      .done(done),
      .hi(hi),
      .lo(lo)
   );

   always #5 clk = ~clk;

   // Architectural result of one operation, returned as {HI, LO}.
   function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint x;
      longint y;
      longint q;
      longint r;
      logic [63:0] p;
      case (o)
         2'b00: begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            p = 64'(x * y);
         end
         2'b01: p = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 32'd0) begin
               p = {a, 32'hFFFF_FFFF};
            end else begin
               x = longint'($signed(a));
               y = longint'($signed(b));
               q = x / y;
               r = x % y;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Model: an accepted op finishes 33 edges later; MT writes only when idle and not launching.
   always @(posedge clk) begin
      logic [63:0] res;
      if (reset) begin
         mHi = '0;
         mLo = '0;
         mDone = 1'b0;
         mCnt = 0;
         modelValid = 1'b1;
      end else begin
         mDone = 1'b0;
         if (mCnt > 0) begin
            mCnt = mCnt - 1;
            if (mCnt == 0) begin
               mHi = pHi;
               mLo = pLo;
               mDone = 1'b1;
            end
         end else if (start) begin
            res = refResult(op, operand_a, operand_b);
            pHi = res[63:32];
            pLo = res[31:0];
            mCnt = 33;
         end else begin
            if (mthi_en) mHi = hi_lo_wdata;
            if (mtlo_en) mLo = hi_lo_wdata;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("busy", {31'b0, busy}, {31'b0, (mCnt != 0)});
         checkOutput("done", {31'b0, done}, {31'b0, mDone});
         checkOutput("hi", hi, mHi);
         checkOutput("lo", lo, mLo);
      end
   end

   // Called at a negedge; holds start for exactly one edge, then scrambles operands.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op = o;
      operand_a = a;
      operand_b = b;
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   task automatic observe(input int cycles, output int busyCycles, output int doneCycles);
      busyCycles = 0;
      doneCycles = 0;
      for (int i = 0; i < cycles; i++) begin
         if (busy) busyCycles++;
         if (done) doneCycles++;
         @(negedge clk);
      end
   endtask

   task automatic waitIdle();
      int i;
      for (i = 0; i < 50; i++) begin
         if (mCnt == 0 && !busy) break;
         @(negedge clk);
      end
      checkOutput("idleTimeout", {31'b0, (i < 50)}, 32'd1);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         4: return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int bc;
      int dc;
      reset = 1'b1;
      start = 1'b0;
      op = 2'b00;
      operand_a = '0;
      operand_b = '0;
      mthi_en = 1'b0;
      mtlo_en = 1'b0;
      hi_lo_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("resetHi", hi, 32'h0);
      checkOutput("resetLo", lo, 32'h0);
      checkOutput("resetBusy", {31'b0, busy}, 32'h0);

      // MULTU max * max: latency and handshake shape
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      observe(40, bc, dc);
      checkOutput("multuBusyCycles", 32'(bc), 32'd33);
      checkOutput("multuDonePulses", 32'(dc), 32'd1);
      checkOutput("multuHi", hi, 32'hFFFF_FFFE);
      checkOutput("multuLo", lo, 32'h0000_0001);

      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5);
      waitIdle();
      checkOutput("multHi", hi, 32'hFFFF_FFFF);
      checkOutput("multLo", lo, 32'hFFFF_FFF1);

      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
      waitIdle();
      checkOutput("divLo", lo, 32'hFFFF_FFFD);
      checkOutput("divHi", hi, 32'hFFFF_FFFF);

      applyStimulus(2'b11, 32'd100, 32'd0);
      observe(40, bc, dc);
      checkOutput("divzBusyCycles", 32'(bc), 32'd33);
      checkOutput("divzHi", hi, 32'h0000_0064);
      checkOutput("divzLo", lo, 32'hFFFF_FFFF);

      applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle();
      checkOutput("divOvfLo", lo, 32'h8000_0000);
      checkOutput("divOvfHi", hi, 32'h0000_0000);

      // second start while busy must be ignored
      applyStimulus(2'b01, 32'd7, 32'd6);
      repeat (3) @(negedge clk);
      start = 1'b1;
      op = 2'b11;
      operand_a = 32'd9;
      operand_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      observe(40, bc, dc);
      checkOutput("ignoreHi", hi, 32'd0);
      checkOutput("ignoreLo", lo, 32'd42);
      checkOutput("ignoreDonePulses", 32'(dc), 32'd1);

      // reset mid-operation aborts it
      applyStimulus(2'b01, 32'd123, 32'd456);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abortBusy", {31'b0, busy}, 32'd0);
      checkOutput("abortHi", hi, 32'd0);
      checkOutput("abortLo", lo, 32'd0);
      observe(40, bc, dc);
      checkOutput("abortDonePulses", 32'(dc), 32'd0);
      applyStimulus(2'b01, 32'd3, 32'd4);
      waitIdle();
      checkOutput("afterAbortLo", lo, 32'd12);

      // MTHI while idle, then MTLO colliding with a start
      mthi_en = 1'b1;
      hi_lo_wdata = 32'h1234_5678;
      @(negedge clk);
      mthi_en = 1'b0;
      checkOutput("mthiHi", hi, 32'h1234_5678);
      mtlo_en = 1'b1;
      hi_lo_wdata = 32'hAAAA_5555;
      @(negedge clk);
      checkOutput("mtloLo", lo, 32'hAAAA_5555);
      hi_lo_wdata = 32'hDEAD_BEEF;
      applyStimulus(2'b11, 32'd50, 32'd7);
      mtlo_en = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("mtloDroppedLo", lo, 32'hAAAA_5555);
      waitIdle();
      checkOutput("mtloResultLo", lo, 32'd7);
      checkOutput("mtloResultHi", hi, 32'd1);

      // randomized traffic with disturbances while busy
      for (int n = 0; n < 120; n++) begin
         int kind;
         int resetAt;
         kind = $urandom_range(0, 9);
         if (kind < 2) begin
            mthi_en = 1'($urandom);
            mtlo_en = 1'($urandom);
            hi_lo_wdata = $urandom;
            @(negedge clk);
            mthi_en = 1'b0;
            mtlo_en = 1'b0;
         end else begin
            mtlo_en = ($urandom_range(0, 3) == 0);
            hi_lo_wdata = $urandom;
            applyStimulus(2'($urandom), pickOperand(), pickOperand());
            mtlo_en = 1'b0;
            resetAt = (kind == 9) ? $urandom_range(1, 32) : -1;
            for (int c = 0; c < 36; c++) begin
               reset = (c == resetAt);
               if (mCnt > 0) begin
                  start = ($urandom_range(0, 5) == 0);
                  op = 2'($urandom);
                  operand_a = $urandom;
                  operand_b = $urandom;
                  mthi_en = ($urandom_range(0, 5) == 0);
                  mtlo_en = ($urandom_range(0, 5) == 0);
                  hi_lo_wdata = $urandom;
               end else begin
                  start = 1'b0;
                  mthi_en = 1'b0;
                  mtlo_en = 1'b0;
               end
               @(negedge clk);
            end
            reset = 1'b0;
            start = 1'b0;
            mthi_en = 1'b0;
            mtlo_en = 1'b0;
            waitIdle();
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
